if_stage: RTL and testbench

//   Instruction-fetch stage. Consumer of the EX stage's branch_target/zero outputs.
//   - Holds the PC and issues single-outstanding fetches to instruction memory.
//   - Loads the IF/ID pipeline register.
//   - Redirects on a taken branch or jump, flushing and dropping stale fetches.
//   - Honours stall from the hazard unit.

---
 rtl/if_stage_if.sv | 25 ++
 rtl/if_stage.sv | 179 +++++++++++++++++
 tb/tb_if_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between if_stage (master) and instruction memory (slave).
// Single outstanding request: one-cycle imem_req pulse, later answered by an imem_rvalid pulse.
interface if_stage_if #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 10
);
    logic                 imem_req;
    logic [ADDR_SIZE-1:0] imem_addr;
    logic                 imem_rvalid;
    logic [WORD_SIZE-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem fetch, IF/ID register, redirect and stall.
// Optional IF_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module if_stage #(
    parameter int unsigned          WORD_SIZE = 32,
    parameter int unsigned          ADDR_SIZE = 10,
    parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0,
    parameter logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 branch,
    input  logic                 jump,
    input  logic                 zero,
    input  logic [ADDR_SIZE-1:0] branch_target,
    input  logic                 stall,
    if_stage_if.master           imem,
    output logic [ADDR_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] if_instr,
    output logic                 if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_stall
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

    localparam logic [ADDR_SIZE-1:0] PC_STEP    = ADDR_SIZE'(4);
    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ~ADDR_SIZE'(3);

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] pc_q, pc_d;
    logic                 req_q, req_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic                 drop_q, drop_d;
    logic [WORD_SIZE-1:0] buf_q, buf_d;
    logic [ADDR_SIZE-1:0] if_pc_q, if_pc_d;
    logic [WORD_SIZE-1:0] if_instr_q, if_instr_d;
    logic                 if_valid_q, if_valid_d;
    logic                 taken;
    logic [ADDR_SIZE-1:0] target;

    always_comb begin
        taken      = jump | (branch & zero);
        target     = branch_target & ALIGN_MASK;
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = 1'b0;
        addr_d     = addr_q;
        drop_d     = drop_q;
        buf_d      = buf_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;

        // Bubble whenever IF/ID is free to move but nothing gets loaded below.
        if (!stall) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end

        if (taken) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            pc_d       = target;
            case (state_q)
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        req_d  = 1'b1;
                        addr_d = target;
                        drop_d = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                default: begin
                    req_d   = 1'b1;
                    addr_d  = target;
                    state_d = S_WAIT;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (drop_q) begin
                            drop_d = 1'b0;
                            req_d  = 1'b1;
                            addr_d = pc_q;
                        end else if (!stall) begin
                            if_pc_d    = addr_q;
                            if_instr_d = imem.imem_rdata;
                            if_valid_d = 1'b1;
                            pc_d       = addr_q + PC_STEP;
                            req_d      = 1'b1;
                            addr_d     = addr_q + PC_STEP;
                        end else begin
                            buf_d   = imem.imem_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if_pc_d    = pc_q;
                        if_instr_d = buf_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + PC_STEP;
                        req_d      = 1'b1;
                        addr_d     = pc_q + PC_STEP;
                        state_d    = S_WAIT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            drop_q     <= 1'b0;
            buf_q      <= NOP_INSTR;
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            drop_q     <= drop_d;
            buf_q      <= buf_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;
    assign if_valid       = if_valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // A valid IF/ID value only appears without stall when it was loaded this cycle.
    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'b0, if_valid_d & ~stall};
        perf_stall_d   = perf_stall_q + {31'b0, stall};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed redirect/stall/wrap scenarios against a 1-cycle imem model.
module tb_if_stage;

    typedef struct packed {
        logic [9:0]  pc;
        logic [31:0] instr;
    } load_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       branch = 1'b0;
    logic       jump = 1'b0;
    logic       zero = 1'b0;
    logic [9:0] branch_target = '0;
    logic       stall = 1'b0;
    logic [9:0] if_pc;
    logic [31:0] if_instr;
    logic       if_valid;
    logic       stall_e = 1'b0;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [9:0] exp_req_q[$];
    load_t      exp_load_q[$];

    if_stage_if #(.WORD_SIZE(32), .ADDR_SIZE(10)) bus ();

    if_stage #(
        .WORD_SIZE(32),
        .ADDR_SIZE(10),
        .RESET_PC(10'h000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .branch(branch),
        .jump(jump),
        .zero(zero),
        .branch_target(branch_target),
        .stall(stall),
        .imem(bus),
        .if_pc(if_pc),
        .if_instr(if_instr),
        .if_valid(if_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: answers one cycle after the request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.imem_rvalid <= 1'b0;
            bus.imem_rdata  <= '0;
        end else begin
            bus.imem_rvalid <= bus.imem_req;
            bus.imem_rdata  <= 32'hA000_0000 | {22'b0, bus.imem_addr};
        end
    end

    always @(posedge clk) stall_e <= stall;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_req(input logic [9:0] a);
        exp_req_q.push_back(a);
    endtask

    task automatic push_load(input logic [9:0] a);
        load_t l;
        l.pc    = a;
        l.instr = 32'hA000_0000 | {22'b0, a};
        exp_load_q.push_back(l);
    endtask

    // Monitor: every request and every fresh IF/ID load is matched against the scoreboard.
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (bus.imem_req) begin
                if (exp_req_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr %h expected no request", bus.imem_addr);
                end else begin
                    check("req_addr", {22'b0, bus.imem_addr}, {22'b0, exp_req_q.pop_front()});
                end
            end
            if (if_valid && !stall_e) begin
                if (exp_load_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_load: got pc %h instr %h expected no load", if_pc, if_instr);
                end else begin
                    load_t l;
                    l = exp_load_q.pop_front();
                    check("load_pc", {22'b0, if_pc}, {22'b0, l.pc});
                    check("load_instr", if_instr, l.instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req(input logic [9:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.imem_req && bus.imem_addr == a) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_req: got no request expected addr %h", a);
        end
    endtask

    task automatic check_flush(input string nm);
        check({nm, "_valid"}, {31'b0, if_valid}, 32'd0);
        check({nm, "_instr"}, if_instr, NOP);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_req", {31'b0, bus.imem_req}, 32'd0);
        check("rst_addr", {22'b0, bus.imem_addr}, 32'h000);
        check("rst_pc", {22'b0, if_pc}, 32'h000);
        check("rst_instr", if_instr, NOP);
        check("rst_valid", {31'b0, if_valid}, 32'd0);

        // Sequential fetch, then jump to 0x100 while 0x008 is outstanding
        push_req(10'h000); push_req(10'h004); push_req(10'h008); push_req(10'h100);
        push_load(10'h000); push_load(10'h004); push_load(10'h100);
        rst_n = 1'b1;
        wait_req(10'h008);
        jump = 1'b1; branch_target = 10'h100;
        tick();
        jump = 1'b0;
        check_flush("jump_flush");

        // Not-taken branch keeps sequential flow; taken branch to 0x043 aligns to 0x040
        push_req(10'h104); push_req(10'h108); push_req(10'h10C); push_req(10'h040);
        push_load(10'h104); push_load(10'h108); push_load(10'h040);
        branch = 1'b1; zero = 1'b0; branch_target = 10'h3F0;
        wait_req(10'h10C);
        zero = 1'b1; branch_target = 10'h043;
        tick();
        branch = 1'b0; zero = 1'b0;
        check_flush("branch_flush");

        // Jump to 0x008, then stall 3 cycles while the 0x010 response arrives
        push_req(10'h044); push_req(10'h008); push_req(10'h00C); push_req(10'h010); push_req(10'h014);
        push_load(10'h008); push_load(10'h00C); push_load(10'h010);
        wait_req(10'h044);
        jump = 1'b1; branch_target = 10'h008;
        tick();
        jump = 1'b0;
        wait_req(10'h010);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_no_req", {31'b0, bus.imem_req}, 32'd0);
            check("stall_hold_pc", {22'b0, if_pc}, 32'h00C);
        end
        stall = 1'b0;
        wait_req(10'h014);
        check("release_pc", {22'b0, if_pc}, 32'h010);
        check("release_valid", {31'b0, if_valid}, 32'd1);

        // PC wraps from 0x3FC to 0x000
        push_req(10'h3F8); push_req(10'h3FC); push_req(10'h000); push_req(10'h004);
        push_load(10'h3F8); push_load(10'h3FC); push_load(10'h000);
        jump = 1'b1; branch_target = 10'h3F8;
        tick();
        jump = 1'b0;
        wait_req(10'h004);

        // Stall into HOLD, then jump to 0x200 while still stalled
        push_req(10'h200); push_req(10'h204);
        push_load(10'h200);
        stall = 1'b1;
        tick();
        tick();
        check("hold_valid", {31'b0, if_valid}, 32'd1);
        check("hold_pc", {22'b0, if_pc}, 32'h000);
        jump = 1'b1; branch_target = 10'h200;
        tick();
        jump = 1'b0; stall = 1'b0;
        check_flush("taken_stall_flush");
        check("taken_stall_req", {22'b0, bus.imem_addr}, 32'h200);
        wait_req(10'h204);

        // Park the stage in HOLD and drain the scoreboard
        stall = 1'b1;
        repeat (8) tick();
        check("req_queue_empty", exp_req_q.size(), 32'd0);
        check("load_queue_empty", exp_load_q.size(), 32'd0);
`ifdef IF_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'd13);
        check("perf_stall", perf_stall, 32'd14);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
